// File: rtl/uart_rx_debug_if.sv
// Receive-side handshake bundle for uart_rx_debug: received byte, valid/ready,
// and status flags. The receiver drives through master; the consumer uses slave.
interface uart_rx_debug_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_debug.sv
// 8-bit UART receiver with a valid/ready output holding register, frame error and sticky overrun.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_debug #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_rx,
    uart_rx_debug_if.master  rx_if
);

    localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] FULL_M1 = 12'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, rx_prev_q;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        rx_s;
    logic        fall;
    logic        frame_ok;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
`endif

    assign rx_s = sync2_q;
    assign fall = rx_prev_q & ~rx_s;

    // Stop bit must be high; with parity, the nine received bits must also have even weight.
`ifdef UART_RX_PARITY_EN
    assign frame_ok = rx_s & ~(^{shift_q, par_q});
`else
    assign frame_ok = rx_s;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = 12'd0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == HALF_M1) begin
                    cnt_d     = 12'd0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == FULL_M1) begin
                    cnt_d     = 12'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == FULL_M1) begin
                    cnt_d   = 12'd0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == FULL_M1) begin
                    cnt_d       = 12'd0;
                    done_d      = frame_ok;
                    frame_err_d = ~frame_ok;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed byte always wins; it counts as lost data only if the old one is not taken now.
        if (done_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_if.rx_ready) begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 12'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            rx_prev_q   <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_debug.md
UART_RX_DEBUG -- requirements
Module: uart_rx_debug

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..4095.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port uart_rx  input  1  serial line; idle high; asynchronous to clk.
REQ-005 SHALL have port rx_data  output  8  last accepted byte.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both high on a clock edge.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-009 SHALL have port overrun  output  1  sticky flag: a byte was lost to overwrite; cleared only by reset.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass uart_rx through a two-flop synchronizer reset to 1; all logic below uses the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP with a bit-period counter and a 3-bit bit index.
REQ-013 IDLE -> START on a synchronized high-to-low transition; the counter is cleared on that transition.
REQ-014 START SHALL resample the line after CLKS_PER_BIT/2 cycles (integer division): if low, clear the counter and go to DATA; if high, return to IDLE with no error (glitch).
REQ-015 DATA SHALL sample once every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; after bit 7, go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-016 STOP SHALL sample after CLKS_PER_BIT cycles: if high (and parity passed), load rx_data and set rx_valid on the next edge; if low, discard the byte and pulse frame_err; in both cases go to IDLE.
REQ-017 Latency: rx_valid rises exactly one clk cycle after the stop-bit sample edge.
REQ-018 rx_valid SHALL stay high and rx_data stable until a handshake edge; rx_valid clears on that edge.
REQ-019 If a new byte is accepted while rx_valid is high and no handshake occurs on that edge, rx_data SHALL be overwritten, rx_valid SHALL stay high, and overrun SHALL set.
REQ-020 If a new byte completes on the same edge as a handshake, no overrun SHALL occur; rx_data takes the new byte and rx_valid stays high.
REQ-021 A framed-error frame SHALL NOT change rx_data, rx_valid, or overrun.
REQ-022 A line held low (break) SHALL produce one frame_err and then wait in IDLE for a new high-to-low transition.

Reset
REQ-023 On rst_n low, asynchronously: FSM -> IDLE; counters and shift register -> 0; rx_data = 8'h00; rx_valid = 0; frame_err = 0; overrun = 0; busy = 0; synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output; the first frame after release is received normally.

Configuration
REQ-025 Macro UART_RX_PARITY_EN: when defined, the PARITY state samples a ninth bit one bit period after bit 7; even parity over data plus parity bit is required, and a mismatch discards the byte and pulses frame_err, checked at STOP time; STOP behaves as in REQ-016.
REQ-026 When UART_RX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and the frame is 10 bits.

Verification
REQ-027 CLKS_PER_BIT=16, send 8'hA5 with valid stop, rx_ready=1 -> rx_valid pulses for one cycle with rx_data=8'hA5, frame_err=0.
REQ-028 Send 8'h3C then 8'hC3 with rx_ready=0 -> rx_data=8'hC3, rx_valid=1, overrun=1; assert rx_ready for one cycle -> rx_valid=0, overrun stays 1.
REQ-029 Send 8'h55 with stop bit driven 0 -> one-cycle frame_err, rx_valid stays 0, rx_data unchanged.
REQ-030 Drive uart_rx low for 5 cycles then high -> return to IDLE, no frame_err, no rx_valid; a following 8'h01 is received correctly.
REQ-031 Assert rst_n low during bit 4 of 8'hFF -> all outputs at reset values; after release, 8'h12 is received correctly.
REQ-032 With UART_RX_PARITY_EN defined: 8'h07 with parity bit 1 -> accepted; with parity bit 0 -> frame_err, no rx_valid.
